// File: rtl/ddp_pkg.sv
// ddp_pkg -- shared constants and types for the datapath blocks.
//   OPERAND_WIDTH      : width of a reduced operand (512)
//   LIMB_SIZE_DEFAULT  : default limb width processed per cycle
//   state_t            : cond_subtractor FSM state encoding
package ddp_pkg;

   localparam int OPERAND_WIDTH     = 512;
   localparam int LIMB_SIZE_DEFAULT = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      SELECT = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/csub_limb.sv
// csub_limb -- combinational single-limb subtractor with borrow chain.
//   a, b        : W-bit operands
//   borrow_in   : borrow from the less significant limb
//   diff        : (a - b - borrow_in) mod 2^W
//   borrow_out  : 1 when a < b + borrow_in
module csub_limb #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         borrow_in,
   output logic [W-1:0] diff,
   output logic         borrow_out
);

   // One extra bit catches the wrap: the result lies in [-2^W, 2^W-1],
   // so bit W is set exactly when the true difference is negative.
   logic [W:0] full;

   assign full       = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
   assign diff       = full[W-1:0];
   assign borrow_out = full[W];

endmodule

// File: rtl/cond_subtractor.sv
// cond_subtractor -- limb-serial conditional subtraction:
//   result = in_x - in_m when in_x >= in_m, else in_x[511:0].
// Fixed latency of 512/LIMB_SIZE + 4 cycles per operation.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, only looked at in IDLE
//   in_x       : 514-bit value (adder result format), captured in LOAD
//   in_m       : 512-bit modulus, captured in LOAD
//   result     : registered reduced value, updated on leaving SELECT
//   done       : one-cycle pulse while in DONE
//   busy       : high in every state but IDLE
//   reduced    : only with COND_SUBTRACTOR_REDUCED_FLAG_EN defined;
//                1 when the subtraction was applied
// LIMB_SIZE must divide 512.
module cond_subtractor
   import ddp_pkg::*;
#(
   parameter int LIMB_SIZE = LIMB_SIZE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [OPERAND_WIDTH+1:0]   in_x,
   input  logic [OPERAND_WIDTH-1:0]   in_m,
   output logic [OPERAND_WIDTH-1:0]   result,
   output logic                       done,
   output logic                       busy
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
   ,
   output logic                       reduced
`endif
);

   localparam int N     = OPERAND_WIDTH / LIMB_SIZE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           cnt;
   logic [OPERAND_WIDTH-1:0]   x_lo;     // rotates; back in place after N limbs
   logic [1:0]                 x_top;
   logic [OPERAND_WIDTH-1:0]   m_sh;
   logic [OPERAND_WIDTH-1:0]   diff_sh;  // filled from the MSB end
   logic                       borrow;

   logic [LIMB_SIZE-1:0]       limb_diff;
   logic                       limb_bout;
   logic [2:0]                 top;
   logic                       neg;

   csub_limb #(.W(LIMB_SIZE)) u_limb (
      .a          (x_lo[LIMB_SIZE-1:0]),
      .b          (m_sh[LIMB_SIZE-1:0]),
      .borrow_in  (borrow),
      .diff       (limb_diff),
      .borrow_out (limb_bout)
   );

   // Sign of x[513:512] - final borrow decides whether x - m went negative.
   assign top = {1'b0, x_top} - {2'b00, borrow};
   assign neg = top[2];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (cnt == CNT_W'(N - 1)) state_nxt = SELECT;
         SELECT:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         x_lo    <= '0;
         x_top   <= '0;
         m_sh    <= '0;
         diff_sh <= '0;
         borrow  <= 1'b0;
         result  <= '0;
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
         reduced <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               x_lo   <= in_x[OPERAND_WIDTH-1:0];
               x_top  <= in_x[OPERAND_WIDTH+1:OPERAND_WIDTH];
               m_sh   <= in_m;
               borrow <= 1'b0;
               cnt    <= '0;
            end
            RUN: begin
               x_lo    <= {x_lo[LIMB_SIZE-1:0], x_lo[OPERAND_WIDTH-1:LIMB_SIZE]};
               m_sh    <= {{LIMB_SIZE{1'b0}}, m_sh[OPERAND_WIDTH-1:LIMB_SIZE]};
               diff_sh <= {limb_diff, diff_sh[OPERAND_WIDTH-1:LIMB_SIZE]};
               borrow  <= limb_bout;
               cnt     <= cnt + CNT_W'(1);
            end
            SELECT: begin
               result <= neg ? x_lo : diff_sh;
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
               reduced <= ~neg;
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_cond_subtractor.sv
module tb_cond_subtractor;

   localparam int LIMB = 64;
   localparam int N    = 512 / LIMB;
   localparam int LAT  = N + 3;   // sampling edge of done, counted from the start edge

   logic         clk = 1'b0;
   logic         reset, start;
   logic [513:0] in_x;
   logic [511:0] in_m;
   logic [511:0] result;
   logic         done, busy;
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
   logic         reduced;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cond_subtractor #(.LIMB_SIZE(LIMB)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .in_x   (in_x),
      .in_m   (in_m),
      .result (result),
      .done   (done),
      .busy   (busy)
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
      ,
      .reduced(reduced)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain arithmetic on wide integers.
   function automatic logic [511:0] model_res(input logic [513:0] x, input logic [511:0] m);
      logic [513:0] mm;
      logic [513:0] d;
      mm = {2'b00, m};
      d  = x - mm;
      if (x >= mm) return d[511:0];
      return x[511:0];
   endfunction

   function automatic logic model_red(input logic [513:0] x, input logic [511:0] m);
      return x >= {2'b00, m};
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
      return r;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, scramble inputs after capture, wait for done
   // (bounded), then check latency, result, flag and pulse width.
   // mid_start pulses start for one cycle while in RUN.
   task automatic run_op(input string tag, input logic [513:0] x, input logic [511:0] m,
                         input logic [511:0] exp_res, input logic exp_red, input bit mid_start);
      int lat;
      @(negedge clk); start = 1'b1; in_x = x; in_m = m;
      @(negedge clk); start = 1'b0; lat = 0;
      @(negedge clk); lat = 1;
      in_x = {2'b11, rand512()}; in_m = rand512();
      while (!done && lat < 40) begin
         @(negedge clk); lat++;
         if (mid_start && lat == 4) start = 1'b1;
         if (mid_start && lat == 5) start = 1'b0;
      end
      check({tag, "_latency"}, 512'(lat + 1), 512'(LAT));
      check({tag, "_result"}, result, exp_res);
      check({tag, "_busy_in_done"}, 512'(busy), 512'(1));
`ifdef COND_SUBTRACTOR_REDUCED_FLAG_EN
      check({tag, "_reduced"}, 512'(reduced), 512'(exp_red));
`else
      if (exp_red === 1'bx) $display("unused");
`endif
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 512'(done), 512'(0));
      check({tag, "_idle_after"}, 512'(busy), 512'(0));
   endtask

   initial begin
      logic [513:0] x;
      logic [511:0] m;
      logic [513:0] hx [3];
      logic [511:0] hm [3];
      int           dcyc [3];
      int           nd, w, extra;

      reset = 1'b1; start = 1'b0; in_x = '0; in_m = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 512'(busy), 512'(0));
      check("reset_done", 512'(done), 512'(0));
      check("reset_result", result, 512'(0));
      reset = 1'b0;

      // Directed cases with hand-derived results.
      run_op("d1000_700", 514'd1000, 512'd700, 512'd300, 1'b1, 1'b0);
      run_op("d699_700", 514'd699, 512'd700, 512'd699, 1'b0, 1'b0);
      x = (514'd1 << 511) + 514'd3;
      m = x[511:0];
      run_op("x_eq_m", x, m, 512'd0, 1'b1, 1'b0);
      x = (514'd1 << 512) + 514'd5;
      m = '1;
      run_op("full_borrow", x, m, 512'd6, 1'b1, 1'b0);
      // Precondition violated: x >= 2m, result wraps mod 2^512.
      x = {2'b11, 512'd10};
      m = 512'd3;
      run_op("precond_viol", x, m, model_res(x, m), 1'b1, 1'b0);

      // Randomised operands against the reference.
      for (int i = 0; i < 8; i++) begin
         m = rand512() | 512'd1;
         x = (i % 2 == 0) ? {2'($urandom_range(0, 1)), rand512()} : {2'b00, rand512()};
         run_op("rand", x, m, model_res(x, m), model_red(x, m), 1'b0);
      end

      // Start pulsed in RUN is ignored: one done, then nothing.
      x = {2'b00, rand512()}; m = rand512();
      run_op("mid_start", x, m, model_res(x, m), model_red(x, m), 1'b1);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      check("mid_start_no_second_op", 512'(extra), 512'(0));

      // Reset in RUN cycle 3 aborts the operation.
      @(negedge clk); start = 1'b1; in_x = 514'd1000; in_m = 512'd700;
      @(negedge clk); start = 1'b0;           // LOAD
      repeat (3) @(negedge clk);              // RUN cycles 1..3
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 512'(busy), 512'(0));
      check("abort_result", result, 512'(0));
      check("abort_done", 512'(done), 512'(0));
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort_no_done", 512'(extra), 512'(0));

      // Reset wins over start in the same cycle.
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      check("reset_prio_busy", 512'(busy), 512'(0));
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("reset_prio_idle", 512'(busy), 512'(0));

      // Start held high: back-to-back operations every N+4 cycles.
      for (int i = 0; i < 3; i++) begin
         hm[i] = rand512() | 512'd1;
         hx[i] = {2'b00, rand512()};
      end
      start = 1'b1; in_x = hx[0]; in_m = hm[0];
      nd = 0; w = 0;
      while (nd < 3 && w < 100) begin
         @(negedge clk); w++;
         if (done) begin
            check("held_result", result, model_res(hx[nd], hm[nd]));
            dcyc[nd] = cyc;
            nd++;
            if (nd < 3) begin in_x = hx[nd]; in_m = hm[nd]; end
            else start = 1'b0;
         end
      end
      check("held_count", 512'(nd), 512'(3));
      if (nd == 3) begin
         check("held_spacing_1", 512'(dcyc[1] - dcyc[0]), 512'(N + 4));
         check("held_spacing_2", 512'(dcyc[2] - dcyc[1]), 512'(N + 4));
      end
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
